// File: rtl/alu_control_fsm.sv
// -----------------------------------------------------------------------------
// alu_control_fsm
//
// Multi-cycle MIPS-style control unit. A Moore FSM steps each instruction
// through FETCH / DECODE and the instruction-specific execute, memory and
// write-back states, and drives the datapath select and strobe lines.
//
// The datapath controls are registered: on every edge the FSM loads the
// control word belonging to the state it is entering, so the outputs are a
// pure function of the current state. Two outputs deliberately bypass the
// register:
//   - alu_cnt in EXEC follows funct combinationally (R-type operation select)
//   - pc_en in BRANCH follows zero combinationally (taken/not-taken)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   opcode     in   [5:0] instruction bits [31:26]
//   funct      in   [5:0] instruction bits [5:0]
//   zero       in   ALU zero flag
//   pc_en      out  PC load enable
//   i_or_d     out  memory address select (0 = PC, 1 = ALUOut)
//   mem_write  out  data memory write strobe
//   ir_write   out  instruction register load
//   reg_dst    out  write register select (0 = rt, 1 = rd)
//   mem_to_reg out  write-back select (0 = ALUOut, 1 = MDR)
//   reg_write  out  register file write enable
//   alu_src_a  out  ALU A select (0 = PC, 1 = reg A)
//   alu_src_b  out  [1:0] ALU B select (B, 4, imm, imm<<2)
//   alu_cnt    out  [3:0] ALU operation (0 add .. 7 slt)
//   pc_source  out  [1:0] PC source (ALU, ALUOut, jump target)
//   state      out  [3:0] current state, for debug
//   illegal    out  sticky unsupported-opcode/funct flag
// -----------------------------------------------------------------------------
module alu_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_cnt,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_NOT = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_cnt;
    logic [1:0] pc_source;
  } ctrl_t;

  // Control word for each state; anything not set stays 0.
  function automatic ctrl_t moore_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_cnt   = ALU_ADD;
        c.pc_source = 2'b00;
        c.pc_en     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_cnt   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_cnt   = ALU_ADD;
      end
      S_MEMRD: c.i_or_d = 1'b1;
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: c.alu_src_a = 1'b1;
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      // pc_en here is replaced by zero at the output.
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_cnt   = ALU_SUB;
        c.pc_source = 2'b01;
      end
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_en     = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_NOR, FN_SLL,
      FN_SRL, FN_AND, FN_OR,  FN_SLT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Unsupported funct maps to add so alu_cnt never leaves 0..7.
  function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_NOR:  return ALU_NOT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  logic   illegal_q;
  logic   illegal_set;

  always_comb begin
    state_d     = S_FETCH;
    illegal_set = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d     = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      // Opcode is held by the IR; anything else here falls back to FETCH.
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: state_d = S_MEMWB;
      S_EXEC: begin
        if (funct_legal(funct)) begin
          state_d = S_RWB;
        end else begin
          state_d     = S_FETCH;
          illegal_set = 1'b1;
        end
      end
      S_ADDIEX: state_d = S_ADDIWB;
      // MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB and unused codes 12-15.
      default: state_d = S_FETCH;
    endcase
  end

  // Control word is loaded for the state being entered, so it lines up
  // with state_q in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= moore_ctrl(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d);
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  assign pc_en      = (state_q == S_BRANCH) ? zero : ctrl_q.pc_en;
  assign alu_cnt    = (state_q == S_EXEC) ? funct_to_alu(funct) : ctrl_q.alu_cnt;
  assign i_or_d     = ctrl_q.i_or_d;
  assign mem_write  = ctrl_q.mem_write;
  assign ir_write   = ctrl_q.ir_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_source  = ctrl_q.pc_source;
  assign state      = state_q;
  assign illegal    = illegal_q;

endmodule
